uart_sequencer: RTL and testbench
=================================

// Module: uart_sequencer
// PURPOSE
//  Bus-master sequencer for the 9600-baud UART register block. Shares the UART transmitter
//  between N_REQ byte-stream requesters using round-robin arbitration. Polls the UART status
//  register and drains the single-entry RX buffer into a valid/ready output stream.
//  Sits between the fabric byte producers/consumers and the UART cs/rw/addr/data port, replacing CPU polling.
// PARAMETERS
//  N_REQ         2   number of TX requesters (1..8)
//  GUARD_CYCLES  8   idle clks after each TX write before the next status poll; covers the busy-flag crossing into clk_50
// PORTS
//  clk            in   1        system clock (same clock as the UART register side)
//  rst            in   1        synchronous, active-high reset
//  req_valid      in   N_REQ    requester i has a byte to send
//  req_data       in   N_REQ*8  byte of requester i, in bits [8i+7:8i]
//  req_ready      out  N_REQ    one-clk pulse: byte of requester i accepted (written to UART)
//  rx_valid       out  1        rx_data holds an unconsumed received byte
//  rx_data        out  8        received byte
//  rx_ready       in   1        consumer takes rx_data when rx_valid & rx_ready
//  rx_overrun     out  1        sticky: UART had RX data while rx_valid was still pending
//  uart_cs        out  1        UART chip select
//  uart_rw        out  1        1 = read, 0 = write
//  uart_addr      out  2        UART register address
//  uart_wdata     out  8        UART write data
//  uart_rdata     in   8        UART registered read data, valid the clk after a read strobe
//  uart_irq       in   1        UART RX-ready level (status bit 1)
// BEHAVIOUR
//  - UART register map: addr 0 write = TX byte; addr 0 read = RX byte, which clears rx-ready.
//    addr 1 read = status: bit0 TX busy, bit1 RX ready.
//  - All outputs are registered.
//  - Reset values: uart_cs=0, uart_rw=1, uart_addr=0, uart_wdata=0, req_ready=0, rx_valid=0,
//    rx_data=0, rx_overrun=0, round-robin pointer=0, state=IDLE.
//  - The UART strobe is asserted for exactly one clk per access. Reads are always followed by
//    a WAIT clk; uart_rdata is sampled at the end of that WAIT clk.
//  - States and transitions:
//    IDLE: go to POLL if (|req_valid) | uart_irq; otherwise stay.
//    POLL: cs=1, rw=1, addr=1. Next state is POLL_WAIT.
//    POLL_WAIT: capture status, then apply in order:
//      (a) bit1 & ~rx_valid -> RX_READ.
//      (b) bit1 & rx_valid -> set rx_overrun, then evaluate (c).
//      (c) ~bit0 & (|req_valid) -> TX_WRITE.
//      (d) otherwise -> IDLE.
//      RX has priority over TX.
//    RX_READ: cs=1, rw=1, addr=0. Next state is RX_WAIT.
//    RX_WAIT: rx_data <= uart_rdata, rx_valid <= 1, then go to IDLE.
//    TX_WRITE: cs=1, rw=0, addr=0, wdata = req_data of grant g, req_ready[g]=1 for this clk only.
//      Advance the round-robin pointer to g+1 (mod N_REQ). Next state is GUARD.
//    GUARD: count GUARD_CYCLES clks, then go to IDLE. The counter reloads on entry.
//  - Grant g is the first asserted req_valid at or after the round-robin pointer, wrapping
//    around. It is latched in POLL_WAIT.
//  - A requester that drops req_valid between POLL_WAIT and TX_WRITE is still written;
//    requesters must hold valid until ready.
//  - rx_valid clears on rx_valid & rx_ready. A same-clk RX_WAIT load wins over the clear.
//  - rx_overrun clears only on rst.
//  - Reset mid-access: all outputs return to reset values on the next clk. No partial write
//    and no req_ready pulse may be emitted.
//  - Worst-case TX latency with UART idle: POLL + POLL_WAIT + TX_WRITE = 3 clks from IDLE.
// STRUCTURE
//  - uart_pkg holds the state enum (IDLE, POLL, POLL_WAIT, RX_READ, RX_WAIT, TX_WRITE, GUARD),
//    UART_ADDR_DATA=2'd0, UART_ADDR_STATUS=2'd1, STAT_TX_BUSY=0, STAT_RX_RDY=1.
//  - Sub-module rr_arbiter(N): inputs req and ptr; outputs grant index and any_req. Purely
//    combinational, reusable elsewhere.
// TESTING
//  1. req_valid=01, data0=0x41, status read 0x00 -> POLL, then write addr0=0x41, req_ready=01
//     for 1 clk, then 8 GUARD clks.
//  2. req_valid=01, status 0x01 (busy) -> no write, return to IDLE, repoll. A write occurs
//     only after status reads 0x00.
//  3. req_valid=11 held, data 0x11/0x22, status always 0x00 -> written bytes 0x11, 0x22, 0x11;
//     req_ready alternates 01, 10, 01.
//  4. uart_irq=1, status 0x02, rdata 0x5A -> addr0 read, rx_valid=1 with rx_data=0x5A,
//     held until rx_ready.
//  5. rx_valid pending, rx_ready=0, status 0x03 -> no RX read, rx_overrun=1, TX still
//     proceeds only if bit0 is 0.
//  6. rst asserted during TX_WRITE -> next clk cs=0, req_ready=0, state IDLE, pointer 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART bus-master sequencer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        POLL_WAIT,
        RX_READ,
        RX_WAIT,
        TX_WRITE,
        GUARD
    } state_e;

    localparam logic [1:0] UART_ADDR_DATA   = 2'd0;
    localparam logic [1:0] UART_ADDR_STATUS = 2'd1;
    localparam int         STAT_TX_BUSY     = 0;
    localparam int         STAT_RX_RDY      = 1;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_sequencer_if.sv
// Requester streams, RX stream and UART register port of the sequencer.
interface uart_sequencer_if #(parameter int N_REQ = 2);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0][7:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  rx_overrun;
    logic                  uart_cs;
    logic                  uart_rw;
    logic [1:0]            uart_addr;
    logic [7:0]            uart_wdata;
    logic [7:0]            uart_rdata;
    logic                  uart_irq;

    modport master (
        input  req_valid, req_data, rx_ready, uart_rdata, uart_irq,
        output req_ready, rx_valid, rx_data, rx_overrun,
               uart_cs, uart_rw, uart_addr, uart_wdata
    );

    modport slave (
        output req_valid, req_data, rx_ready, uart_rdata, uart_irq,
        input  req_ready, rx_valid, rx_data, rx_overrun,
               uart_cs, uart_rw, uart_addr, uart_wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] grant_o,
    output logic          any_req_o
);

    function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    // Scan from the far end so the nearest request to ptr is the last one written.
    always_comb begin
        grant_o   = ptr_i;
        any_req_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[rot(ptr_i, k)]) begin
                grant_o   = rot(ptr_i, k);
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_sequencer.sv
// Polls the UART status register, drains RX into a stream and round-robins TX
// bytes from N_REQ requesters onto the UART data register.
module uart_sequencer
    import uart_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int GUARD_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_sequencer_if.master  bus
);

    localparam int             PW         = idx_w(N_REQ);
    localparam int             CW         = $clog2(GUARD_CYCLES + 1);
    localparam logic [CW-1:0]  GUARD_LOAD = CW'(GUARD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      grant_q, grant_d;
    logic [CW-1:0]      gcnt_q, gcnt_d;
    logic               cs_q, cs_d;
    logic               rw_q, rw_d;
    logic [1:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic               rx_valid_q, rx_valid_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               overrun_q, overrun_d;

    logic [PW-1:0]      arb_grant;
    logic               arb_any;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req_i     (bus.req_valid),
        .ptr_i     (ptr_q),
        .grant_o   (arb_grant),
        .any_req_o (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        gcnt_d     = gcnt_q;
        wdata_d    = wdata_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        overrun_d  = overrun_q;

        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            IDLE: if ((|bus.req_valid) || bus.uart_irq) state_d = POLL;
            POLL: state_d = POLL_WAIT;
            POLL_WAIT: begin
                grant_d = arb_grant;
                state_d = IDLE;
                // RX drains first; an already-full RX stream marks overrun and lets TX try.
                if (bus.uart_rdata[STAT_RX_RDY] && !rx_valid_q) begin
                    state_d = RX_READ;
                end else begin
                    if (bus.uart_rdata[STAT_RX_RDY]) overrun_d = 1'b1;
                    if (!bus.uart_rdata[STAT_TX_BUSY] && arb_any) begin
                        state_d = TX_WRITE;
                        wdata_d = bus.req_data[arb_grant];
                    end
                end
            end
            RX_READ: state_d = RX_WAIT;
            RX_WAIT: begin
                rx_data_d  = bus.uart_rdata;
                rx_valid_d = 1'b1;
                state_d    = IDLE;
            end
            TX_WRITE: begin
                ptr_d   = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
                gcnt_d  = GUARD_LOAD;
                state_d = GUARD;
            end
            GUARD: begin
                if (gcnt_q == '0) state_d = IDLE;
                else              gcnt_d  = gcnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered, so they follow the state being entered.
        cs_d        = (state_d == POLL) || (state_d == RX_READ) || (state_d == TX_WRITE);
        rw_d        = (state_d != TX_WRITE);
        addr_d      = (state_d == POLL) ? UART_ADDR_STATUS : UART_ADDR_DATA;
        req_ready_d = '0;
        if (state_d == TX_WRITE) req_ready_d[grant_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            gcnt_q      <= '0;
            cs_q        <= 1'b0;
            rw_q        <= 1'b1;
            addr_q      <= UART_ADDR_DATA;
            wdata_q     <= '0;
            req_ready_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            gcnt_q      <= gcnt_d;
            cs_q        <= cs_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.uart_cs    = cs_q;
    assign bus.uart_rw    = rw_q;
    assign bus.uart_addr  = addr_q;
    assign bus.uart_wdata = wdata_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_sequencer.sv
// Bench for uart_sequencer: behavioural UART register model, queued requesters,
// and a round-robin reference for the order of written bytes.
module tb_uart_sequencer;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_sequencer_if #(.N_REQ(N)) bus ();

    uart_sequencer #(.N_REQ(N), .GUARD_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int n_polls = 0;
    int n_rxreads = 0;
    int model_ptr = 0;

    logic       tx_busy = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rd_val = 8'h00;
    bit         rd_pend = 1'b0;
    bit         prev_cs = 1'b0;
    bit         busy_rand = 1'b0;
    bit         rx_rand = 1'b0;

    logic [7:0]   rq[N][$];
    logic [7:0]   wr_q[$];
    logic [N-1:0] rdy_q[$];
    logic [7:0]   rx_got[$];

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = (rq[i].size() > 0);
            bus.req_data[i]  = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
    endtask

    // One clock: sample just after the edge, play the UART and the requesters.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.uart_rdata = rd_pend ? rd_val : 8'($urandom);
        rd_pend = 1'b0;
        if (busy_rand) tx_busy = ($urandom_range(0, 2) == 0);
        if (rx_rand) bus.rx_ready = ($urandom_range(0, 1) == 1);
        if (bus.rx_valid && bus.rx_ready) rx_got.push_back(bus.rx_data);
        checks++;
        if ((bus.req_ready != '0 && !(bus.uart_cs && !bus.uart_rw)) || (bus.uart_cs && prev_cs)) begin
            errs++;
            $display("FAIL strobe cyc=%0d: cs=%b prev_cs=%b rw=%b req_ready=%b (want single-clk cs, ready only with write)",
                     cyc, bus.uart_cs, prev_cs, bus.uart_rw, bus.req_ready);
        end
        prev_cs = bus.uart_cs;
        if (bus.uart_cs && bus.uart_rw) begin
            rd_pend = 1'b1;
            if (bus.uart_addr == 2'd1) begin
                rd_val = {6'd0, rx_rdy, tx_busy};
                n_polls++;
            end else begin
                rd_val = rx_byte;
                rx_rdy = 1'b0;
                n_rxreads++;
            end
        end else if (bus.uart_cs) begin
            wr_q.push_back(bus.uart_wdata);
            rdy_q.push_back(bus.req_ready);
            for (int i = 0; i < N; i++)
                if (bus.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        bus.uart_irq = rx_rdy;
        drive_reqs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic run_until_writes(input int n, input int budget, input string tag);
        int k = 0;
        while (wr_q.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (wr_q.size() < n) begin
            errs++;
            $display("FAIL %s timeout: writes=%0d required=%0d", tag, wr_q.size(), n);
        end
    endtask

    task automatic wait_rx_valid(input int budget, input string tag);
        int k = 0;
        while (!bus.rx_valid && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (!bus.rx_valid) begin
            errs++;
            $display("FAIL %s timeout: rx_valid never set", tag);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (bus.uart_cs !== 1'b0 || bus.uart_rw !== 1'b1 || bus.uart_addr !== 2'd0 ||
            bus.uart_wdata !== 8'h00 || bus.req_ready !== '0 || bus.rx_valid !== 1'b0 ||
            bus.rx_data !== 8'h00 || bus.rx_overrun !== 1'b0) begin
            errs++;
            $display("FAIL %s: cs=%b rw=%b addr=%0d wdata=%h rdy=%b rxv=%b rxd=%h ovr=%b required 0 1 0 00 00 0 00 0",
                     tag, bus.uart_cs, bus.uart_rw, bus.uart_addr, bus.uart_wdata, bus.req_ready,
                     bus.rx_valid, bus.rx_data, bus.rx_overrun);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_vals("reset_values");
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (n_polls != 0 || wr_q.size() != 0) begin
            errs++;
            $display("FAIL idle_quiet: polls=%0d writes=%0d required 0 0", n_polls, wr_q.size());
        end
    endtask

    task automatic test_single_tx();
        int n = 0;
        int g = 0;
        wr_q.delete();
        rdy_q.delete();
        rq[0].push_back(8'h41);
        drive_reqs();
        while (wr_q.size() == 0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 3) begin errs++; $display("FAIL tx_latency: %0d clks required 3", n); end
        checks++;
        if (wr_q.size() == 0 || wr_q[0] !== 8'h41 || rdy_q[0] !== 2'b01) begin
            errs++;
            $display("FAIL tx_byte: writes=%0d byte=%h ready=%b required 41 01",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'hxx, (rdy_q.size() > 0) ? rdy_q[0] : 2'bxx);
        end
        rq[0].push_back(8'h42);
        drive_reqs();
        do begin
            step();
            g++;
            if (g == 1) begin
                checks++;
                if (bus.req_ready !== 2'b00) begin
                    errs++;
                    $display("FAIL ready_pulse: req_ready=%b required 00", bus.req_ready);
                end
            end
        end while (!bus.uart_cs && g < 30);
        checks++;
        if (g != 10) begin errs++; $display("FAIL guard_gap: next strobe after %0d clks required 10", g); end
        run_until_writes(2, 20, "tx_second");
        checks++;
        if (wr_q.size() > 1 && wr_q[1] !== 8'h42) begin
            errs++;
            $display("FAIL tx_second_byte: %h required 42", wr_q[1]);
        end
    endtask

    task automatic test_busy();
        int p0;
        int w0;
        w0 = wr_q.size();
        tx_busy = 1'b1;
        rq[0].push_back(8'h33);
        drive_reqs();
        p0 = n_polls;
        for (int i = 0; i < 25; i++) step();
        checks++;
        if (wr_q.size() != w0) begin errs++; $display("FAIL busy_no_write: writes=%0d required %0d", wr_q.size(), w0); end
        checks++;
        if (n_polls - p0 < 5) begin errs++; $display("FAIL busy_repoll: polls=%0d required >=5", n_polls - p0); end
        tx_busy = 1'b0;
        run_until_writes(w0 + 1, 20, "busy_release");
        checks++;
        if (wr_q.size() > w0 && wr_q[w0] !== 8'h33) begin
            errs++;
            $display("FAIL busy_byte: %h required 33", wr_q[w0]);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]   eb[3] = '{8'h11, 8'h22, 8'h11};
        logic [N-1:0] er[3] = '{2'b01, 2'b10, 2'b01};
        int w0;
        do_reset();
        w0 = wr_q.size();
        rq[0].push_back(8'h11);
        rq[0].push_back(8'h11);
        rq[1].push_back(8'h22);
        drive_reqs();
        run_until_writes(w0 + 3, 100, "rr");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_q.size() > w0 + i && (wr_q[w0 + i] !== eb[i] || rdy_q[w0 + i] !== er[i])) begin
                errs++;
                $display("FAIL rr_%0d: byte=%h ready=%b required %h %b",
                         i, wr_q[w0 + i], rdy_q[w0 + i], eb[i], er[i]);
            end
        end
        model_ptr = 1;
    endtask

    task automatic test_rx();
        int r0;
        r0 = n_rxreads;
        bus.rx_ready = 1'b0;
        rx_byte = 8'h5A;
        rx_rdy = 1'b1;
        bus.uart_irq = 1'b1;
        wait_rx_valid(20, "rx");
        checks++;
        if (bus.rx_data !== 8'h5A || n_rxreads - r0 != 1) begin
            errs++;
            $display("FAIL rx_data: data=%h reads=%0d required 5a 1", bus.rx_data, n_rxreads - r0);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A) begin
            errs++;
            $display("FAIL rx_hold: valid=%b data=%h required 1 5a", bus.rx_valid, bus.rx_data);
        end
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        checks++;
        if (bus.rx_valid !== 1'b0) begin errs++; $display("FAIL rx_clear: valid=%b required 0", bus.rx_valid); end
    endtask

    task automatic test_random();
        logic [7:0] m[N][$];
        logic [7:0] eb[$];
        int         ei[$];
        logic [7:0] rx_exp[$];
        int         w0;
        int         n_rx;
        int         k;
        int         p;
        for (int round = 0; round < 3; round++) begin
            eb.delete();
            ei.delete();
            rx_exp.delete();
            rx_got.delete();
            w0 = wr_q.size();
            for (int i = 0; i < N; i++) begin
                int len = $urandom_range(0, 5);
                for (int j = 0; j < len; j++) rq[i].push_back(8'($urandom));
                m[i] = rq[i];
            end
            // Reference: repeatedly take the nearest non-empty requester at/after the pointer.
            p = model_ptr;
            for (int n = 0; n < 12; n++) begin
                for (int kk = 0; kk < N; kk++) begin
                    int idx = (p + kk) % N;
                    if (m[idx].size() > 0) begin
                        eb.push_back(m[idx].pop_front());
                        ei.push_back(idx);
                        p = (idx + 1) % N;
                        break;
                    end
                end
            end
            model_ptr = p;
            n_rx = $urandom_range(0, 3);
            drive_reqs();
            busy_rand = 1'b1;
            rx_rand = 1'b1;
            k = 0;
            while ((wr_q.size() < w0 + eb.size() || rx_got.size() < n_rx) && k < 4000) begin
                step();
                k++;
                if (rx_exp.size() < n_rx && rx_got.size() == rx_exp.size() && !bus.rx_valid &&
                    !rx_rdy && $urandom_range(0, 7) == 0) begin
                    rx_byte = 8'($urandom);
                    rx_rdy = 1'b1;
                    rx_exp.push_back(rx_byte);
                end
            end
            busy_rand = 1'b0;
            rx_rand = 1'b0;
            tx_busy = 1'b0;
            bus.rx_ready = 1'b0;
            checks++;
            if (wr_q.size() != w0 + eb.size() || rx_got.size() != n_rx) begin
                errs++;
                $display("FAIL rand_count r%0d: writes=%0d rx=%0d required %0d %0d",
                         round, wr_q.size() - w0, rx_got.size(), eb.size(), n_rx);
            end
            for (int i = 0; i < eb.size() && w0 + i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[w0 + i] !== eb[i] || rdy_q[w0 + i] !== (N'(1) << ei[i])) begin
                    errs++;
                    $display("FAIL rand_tx r%0d #%0d: byte=%h ready=%b required %h req%0d",
                             round, i, wr_q[w0 + i], rdy_q[w0 + i], eb[i], ei[i]);
                end
            end
            for (int i = 0; i < rx_got.size() && i < rx_exp.size(); i++) begin
                checks++;
                if (rx_got[i] !== rx_exp[i]) begin
                    errs++;
                    $display("FAIL rand_rx r%0d #%0d: %h required %h", round, i, rx_got[i], rx_exp[i]);
                end
            end
            checks++;
            if (bus.rx_overrun !== 1'b0) begin errs++; $display("FAIL rand_overrun: %b required 0", bus.rx_overrun); end
            for (int i = 0; i < 12; i++) step();
        end
    endtask

    task automatic test_overrun();
        int r0;
        int w0;
        rx_byte = 8'hA7;
        rx_rdy = 1'b1;
        bus.uart_irq = 1'b1;
        wait_rx_valid(20, "ovr_first");
        rx_byte = 8'hC3;
        rx_rdy = 1'b1;
        bus.uart_irq = 1'b1;
        tx_busy = 1'b1;
        rq[1].push_back(8'h66);
        drive_reqs();
        r0 = n_rxreads;
        w0 = wr_q.size();
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (bus.rx_overrun !== 1'b1 || n_rxreads != r0 || wr_q.size() != w0 || bus.rx_data !== 8'hA7) begin
            errs++;
            $display("FAIL overrun: ovr=%b rxreads=%0d writes=%0d data=%h required 1 0 0 a7",
                     bus.rx_overrun, n_rxreads - r0, wr_q.size() - w0, bus.rx_data);
        end
        tx_busy = 1'b0;
        run_until_writes(w0 + 1, 30, "ovr_tx");
        checks++;
        if (wr_q.size() > w0 && wr_q[w0] !== 8'h66) begin errs++; $display("FAIL ovr_tx_byte: %h required 66", wr_q[w0]); end
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        wait_rx_valid(30, "ovr_second");
        checks++;
        if (bus.rx_data !== 8'hC3 || bus.rx_overrun !== 1'b1) begin
            errs++;
            $display("FAIL ovr_second: data=%h ovr=%b required c3 1", bus.rx_data, bus.rx_overrun);
        end
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int w0;
        do_reset();
        check_reset_vals("reset_clears");
        rq[0].push_back(8'hA1);
        rq[1].push_back(8'hB1);
        drive_reqs();
        while (!(bus.uart_cs && !bus.uart_rw) && k < 30) begin
            step();
            k++;
        end
        checks++;
        if (!(bus.uart_cs && !bus.uart_rw)) begin errs++; $display("FAIL rmid_reach: no TX_WRITE seen"); end
        rst = 1'b1;
        step();
        checks++;
        if (bus.uart_cs !== 1'b0 || bus.req_ready !== 2'b00 || bus.uart_rw !== 1'b1) begin
            errs++;
            $display("FAIL rmid_outputs: cs=%b ready=%b rw=%b required 0 00 1",
                     bus.uart_cs, bus.req_ready, bus.uart_rw);
        end
        rst = 1'b0;
        model_ptr = 0;
        rq[0].push_back(8'hA2);
        drive_reqs();
        w0 = wr_q.size();
        run_until_writes(w0 + 1, 30, "rmid_after");
        checks++;
        if (wr_q.size() > w0 && (wr_q[w0] !== 8'hA2 || rdy_q[w0] !== 2'b01)) begin
            errs++;
            $display("FAIL rmid_ptr: byte=%h ready=%b required a2 01", wr_q[w0], rdy_q[w0]);
        end
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.rx_ready   = 1'b0;
        bus.uart_rdata = 8'h00;
        bus.uart_irq   = 1'b0;
        test_reset();
        test_single_tx();
        test_busy();
        test_round_robin();
        test_rx();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
